// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one word-aligned request at a time to a
// combinational instruction memory, buffers {PC, instruction} pairs in a small FIFO and
// hands them to decode over valid/ready. Redirects flush everything in flight.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add fetch_fault_o. Misaligned redirect
// targets then raise a sticky fault that blocks fetching until an aligned redirect arrives.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [63:0] instr_pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fetch_fault_o,
`endif
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     addr_q;
    logic            first_q;
    logic [31:0]     data_q [FIFO_DEPTH];
    logic [63:0]     pc_q   [FIFO_DEPTH];
    logic [PtrW-1:0] rptr_q, wptr_q;
    logic [CntW-1:0] count_q;

    logic [63:0]     redirect_tgt;
    logic            fault_blk;
    logic            fifo_full;
    logic            issue;
    logic            push;
    logic            pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;

    assign redirect_tgt  = redirect_pc_i;
    assign fault_blk     = fault_q;
    assign fetch_fault_o = fault_q;

    // Sticky fault: every redirect re-evaluates it from the target's alignment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
        end else if (redirect_i) begin
            fault_q <= (redirect_pc_i[1:0] != 2'b00);
        end
    end
`else
    logic unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc_i[63:2], 2'b00};
    assign fault_blk           = 1'b0;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
`endif

    assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
    // A request is only launched when its response is guaranteed a FIFO slot.
    assign issue = (state_q == StIdle) && !redirect_i && !fifo_full && !fault_blk;
    // A redirect drops any response or pop happening in the same cycle.
    assign push  = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    assign pop   = instr_valid_o && instr_ready_i && !redirect_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; responses seen in StIdle are stale and ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid_i) state_d = StIdle;
                else if (redirect_i) state_d = StDiscard;
            end
            StDiscard: begin
                if (imem_rvalid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: request pulses only in the first cycle of StWait; FIFO head shown directly.
    always_comb begin
        imem_req_o    = (state_q == StWait) && first_q;
        imem_addr_o   = addr_q;
        instr_valid_o = (count_q != '0);
        instr_o       = data_q[rptr_q];
        instr_pc_o    = pc_q[rptr_q];
    end

    // Fetch PC: a redirect overrides the sequential increment (which wraps silently).
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) fetch_pc_d = redirect_tgt;
        else if (issue) fetch_pc_d = fetch_pc_q + 64'd4;
    end

    // Fetch PC, held request address and first-cycle flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            first_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            first_q    <= issue;
            if (issue) addr_q <= fetch_pc_q;
        end
    end

    // Instruction FIFO; a redirect empties it regardless of a concurrent push or pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (redirect_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[wptr_q] <= imem_rdata_i;
                pc_q[wptr_q]   <= addr_q;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. A memory responder answers each request
// after a programmable latency with word = addr >> 2. The reference model is a pair of
// expected streams: the address of the next request and the PC of the next instruction
// decode should receive; redirects restart both at the target.
module tb_instruction_fetch_unit;
    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .redirect_i    (redirect),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_fault_o (fetch_fault),
`endif
        .redirect_pc_i (redirect_pc)
    );

    always #5 clk = ~clk;

    int          mem_lat  = 1;
    int          pend_cnt = 0;
    logic [63:0] pend_addr;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_req;
    logic [63:0] exp_del;
    logic [63:0] last_del_pc;
    int          n_req;
    int          n_del;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[33:2];
    endfunction

    function automatic logic [63:0] tgt_of(input logic [63:0] pc);
`ifdef FETCH_MISALIGN_CHECK_EN
        return pc;
`else
        return {pc[63:2], 2'b00};
`endif
    endfunction

    // Memory: responds mem_lat cycles after seeing a request; keeps a pending
    // response across reset so a stale reply can land afterwards.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend_addr   = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(pend_addr);
                end
            end
            if (imem_req === 1'b1) begin
                pend_addr = imem_addr;
                pend_cnt  = mem_lat;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Score this cycle's handshakes against the model, then advance one clock.
    task automatic step();
        if (rst_n === 1'b1) begin
            if (imem_req === 1'b1) begin
                chk("req_addr", imem_addr, exp_req);
                exp_req = exp_req + 64'd4;
                n_req++;
            end
            if (redirect) begin
                exp_req = tgt_of(redirect_pc);
                exp_del = tgt_of(redirect_pc);
            end else if (instr_valid === 1'b1 && instr_ready) begin
                chk("instr_pc", instr_pc, exp_del);
                chk("instr", 64'(instr), 64'(word_of(exp_del)));
                last_del_pc = instr_pc;
                exp_del     = exp_del + 64'd4;
                n_del++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        repeat (6) step();
        rst_n       = 1'b1;
        exp_req     = RESET_PC;
        exp_del     = RESET_PC;
        n_req       = 0;
        n_del       = 0;
    endtask

    task automatic run_until_del(input string tag, input int target, input int budget);
        int b = budget;
        while (n_del < target && b > 0) begin
            step();
            b--;
        end
        if (n_del < target) chk(tag, 64'(n_del), 64'(target));
    endtask

    task automatic wait_req(input string tag, input logic [63:0] exp_addr);
        int b = 40;
        while (imem_req !== 1'b1 && b > 0) begin
            step();
            b--;
        end
        if (imem_req === 1'b1) chk(tag, imem_addr, exp_addr);
        else chk({tag, "_timeout"}, 64'(imem_req), 64'd1);
    endtask

    initial begin
        int b;
        int r0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        exp_req     = RESET_PC;
        exp_del     = RESET_PC;
        last_del_pc = '0;
        n_req       = 0;
        n_del       = 0;

        // 1: reset values, then in-order delivery with a 1-cycle memory.
        do_reset();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_pc", instr_pc, 64'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_fault", 64'(fetch_fault), 64'd0);
`endif
        mem_lat     = 1;
        instr_ready = 1'b1;
        run_until_del("t1_deliver", 4, 60);
        chk("t1_last_pc", last_del_pc, 64'hC);

        // 2: decode stalled; exactly FIFO_DEPTH requests, then drain in order.
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        repeat (20) step();
        chk("t2_req_count", 64'(n_req), 64'(FIFO_DEPTH));
        chk("t2_req_idle", 64'(imem_req), 64'd0);
        chk("t2_valid", 64'(instr_valid), 64'd1);
        instr_ready = 1'b1;
        run_until_del("t2_drain", 6, 80);
        chk("t2_last_pc", last_del_pc, 64'd20);

        // 3: redirect while the fetch of 0x8 is outstanding with 3-cycle latency.
        do_reset();
        mem_lat     = 3;
        instr_ready = 1'b1;
        b = 60;
        while (!(imem_req === 1'b1 && imem_addr == 64'h8) && b > 0) begin
            step();
            b--;
        end
        chk("t3_saw_req8", imem_addr, 64'h8);
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        step();
        redirect    = 1'b0;
        wait_req("t3_req_after_redirect", 64'h100);
        r0 = n_del;
        run_until_del("t3_deliver", r0 + 1, 40);
        chk("t3_first_pc", last_del_pc, 64'h100);

        // 4: redirect in the same cycle as a response and a pop.
        do_reset();
        mem_lat     = 2;
        instr_ready = 1'b0;
        b = 60;
        while (!(imem_rvalid === 1'b1 && instr_valid === 1'b1) && b > 0) begin
            step();
            b--;
        end
        chk("t4_setup", 64'(imem_rvalid && instr_valid), 64'd1);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("t4_flush_empty", 64'(instr_valid), 64'd0);
        wait_req("t4_req_after_redirect", 64'h300);

        // 5: reset mid-fetch, stale response arrives right after release.
        do_reset();
        mem_lat     = 4;
        instr_ready = 1'b1;
        b = 60;
        while (!(imem_req === 1'b1 && imem_addr == 64'h8) && b > 0) begin
            step();
            b--;
        end
        step();
        rst_n = 1'b0;
        b = 20;
        while (imem_rvalid !== 1'b1 && b > 0) begin
            step();
            b--;
        end
        chk("t5_late_rvalid", 64'(imem_rvalid), 64'd1);
        rst_n   = 1'b1;
        exp_req = RESET_PC;
        exp_del = RESET_PC;
        n_req   = 0;
        n_del   = 0;
        wait_req("t5_first_req", RESET_PC);
        run_until_del("t5_deliver", 2, 60);
        chk("t5_last_pc", last_del_pc, 64'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
        // 6: misaligned redirect faults and blocks; aligned redirect recovers.
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        run_until_del("t6_warm", 2, 40);
        redirect    = 1'b1;
        redirect_pc = 64'h102;
        step();
        redirect    = 1'b0;
        chk("t6_fault_set", 64'(fetch_fault), 64'd1);
        chk("t6_flushed", 64'(instr_valid), 64'd0);
        r0 = n_req;
        repeat (10) step();
        chk("t6_no_req", 64'(n_req - r0), 64'd0);
        chk("t6_fault_sticky", 64'(fetch_fault), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        step();
        redirect    = 1'b0;
        chk("t6_fault_clear", 64'(fetch_fault), 64'd0);
        wait_req("t6_req_after_fix", 64'h200);
        r0 = n_del;
        run_until_del("t6_deliver", r0 + 2, 40);
`endif

        // Randomized traffic: latency, decode back-pressure and redirects.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(1, 3);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = {32'h0, $urandom} & 64'h0000_0000_00FF_FFFF;
`ifdef FETCH_MISALIGN_CHECK_EN
            redirect_pc[1:0] = 2'b00;
`endif
            step();
        end
        redirect = 1'b0;
        chk("rand_progress", 64'(n_del > 40), 64'd1);

        // PC increment wraps past the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        instr_ready = 1'b1;
        mem_lat     = 1;
        step();
        redirect = 1'b0;
        r0 = n_del;
        run_until_del("wrap_deliver", r0 + 3, 60);
        chk("wrap_pc", last_del_pc, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
